// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package sp_ram_arb_pkg;

   localparam int unsigned MAX_PORTS      = 4;
   localparam int unsigned CONFLICT_CNT_W = 16;

   // Sized for the largest supported configuration so one type serves every build.
   typedef logic [$clog2(MAX_PORTS)-1:0] port_id_t;

   function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sp_ram_arb_pick.sv
// Combinational picker: first requester at or after start_i, wrapping to index 0.
module sp_ram_arb_pick
   import sp_ram_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  port_id_t             start_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output port_id_t             gnt_id_o
);

   logic found;

   // Two passes: ports at/above the start pointer first, then the wrapped-around remainder.
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && req_i[i] && (i >= int'(start_i))) begin
            gnt_o[i] = 1'b1;
            gnt_id_o = port_id_t'(i);
            found    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            gnt_id_o = port_id_t'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Single-port SRAM arbiter with req/gnt/rvalid handshake and 1-cycle response pipeline.
// Define SP_RAM_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS-1:0]              req_i,
   output logic [NUM_PORTS-1:0]              gnt_o,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_PORTS-1:0]              we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_PORTS-1:0]              rvalid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
   output logic                              ram_en_o,
   output logic [ADDR_WIDTH-1:0]             ram_addr_o,
   output logic                              ram_we_o,
   output logic [DATA_WIDTH/8-1:0]           ram_be_o,
   output logic [DATA_WIDTH-1:0]             ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]             ram_rdata_i,
   output logic [CONFLICT_CNT_W-1:0]         conflict_cnt_o
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
   localparam port_id_t LAST_PORT = port_id_t'(NUM_PORTS - 1);
   localparam logic [NUM_PORTS-1:0] REQ_ONE = {{(NUM_PORTS - 1){1'b0}}, 1'b1};

   port_id_t                  last_gnt_q;
   port_id_t                  pend_id_q;
   logic                      pend_valid_q;
   logic [CONFLICT_CNT_W-1:0] conflict_cnt_q;
   port_id_t                  start_ptr;
   port_id_t                  gnt_id;
   logic                      gnt_any;
   logic                      multi_req;

`ifdef SP_RAM_ARB_RR_EN
   always_comb begin
      start_ptr = (last_gnt_q == LAST_PORT) ? '0 : last_gnt_q + port_id_t'(1);
   end
`else
   logic unused_last_gnt;
   assign start_ptr       = '0;
   assign unused_last_gnt = ^last_gnt_q;
`endif

   sp_ram_arb_pick #(
      .NUM_PORTS(NUM_PORTS)
   ) u_pick (
      .req_i   (req_i),
      .start_i (start_ptr),
      .gnt_o   (gnt_o),
      .gnt_id_o(gnt_id)
   );

   assign gnt_any   = |gnt_o;
   // More than one bit set iff clearing the lowest set bit leaves something behind.
   assign multi_req = |(req_i & (req_i - REQ_ONE));

   always_comb begin
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt_o[i]) begin
            ram_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            ram_we_o    = we_i[i];
            ram_be_o    = be_i[i*BE_WIDTH +: BE_WIDTH];
            ram_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign ram_en_o = gnt_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q     <= LAST_PORT;
         pend_id_q      <= '0;
         pend_valid_q   <= 1'b0;
         conflict_cnt_q <= '0;
      end else begin
         pend_valid_q <= gnt_any;
         if (gnt_any) begin
            last_gnt_q <= gnt_id;
            pend_id_q  <= gnt_id;
         end
         if (multi_req) begin
            conflict_cnt_q <= sat_inc(conflict_cnt_q);
         end
      end
   end

   always_comb begin
      rvalid_o = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rvalid_o[i] = pend_valid_q && (pend_id_q == port_id_t'(i));
      end
   end

   assign rdata_o        = {NUM_PORTS{ram_rdata_i}};
   assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: vector table, directed corner cases, random vs model.
module tb_sp_ram_arbiter;

   localparam int NP = 2;
   localparam int AW = 15;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP-1:0]    req, gnt, we, rvalid;
   logic [NP*AW-1:0] addr;
   logic [NP*BW-1:0] be;
   logic [NP*DW-1:0] wdata, rdata;
   logic             ram_en, ram_we;
   logic [AW-1:0]    ram_addr;
   logic [BW-1:0]    ram_be;
   logic [DW-1:0]    ram_wdata;
   logic [DW-1:0]    ram_rdata = '0;
   logic [15:0]      cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sp_ram_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .ram_en_o(ram_en),
      .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata), .conflict_cnt_o(cnt)
   );

   // Behavioural SRAM with one-cycle registered read.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < BW; b++) if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      req = '0; we = '0; addr = '0; be = '0; wdata = '0;
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [BW-1:0] bb, input logic [DW-1:0] d,
                         output logic [DW-1:0] got);
      logic [NP-1:0] eg;
      eg = '0;
      eg[p] = 1'b1;
      idle_all();
      req[p] = 1'b1; we[p] = w; addr[p*AW +: AW] = a; be[p*BW +: BW] = bb;
      wdata[p*DW +: DW] = d;
      #1;
      chk("acc_gnt", gnt, eg);
      chk("acc_ram_addr", ram_addr, a);
      chk("acc_ram_we", ram_we, w);
      tick();
      idle_all();
      chk("acc_rvalid", rvalid, eg);
      got = rdata[p*DW +: DW];
   endtask

   typedef struct {
      logic [NP-1:0] req;
      logic [NP-1:0] gnt_rr;
      logic [NP-1:0] gnt_fp;
   } vec_t;
   vec_t tbl[8];

   task automatic run_random(input int cycles);
      logic          pend [NP];
      logic          p_we [NP];
      logic [AW-1:0] p_addr [NP];
      logic [BW-1:0] p_be [NP];
      logic [DW-1:0] p_data [NP];
      logic [DW-1:0] ref_mem [16];
      int            m_last, m_cnt, w, c;
      logic [NP-1:0] exp_rv, exp_gnt;
      logic          exp_rd;
      logic [DW-1:0] exp_data;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      for (int p = 0; p < NP; p++) pend[p] = 1'b0;
      m_last = NP - 1; m_cnt = 0; exp_rv = '0; exp_rd = 1'b0; exp_data = '0;
      do_reset();
      for (int cyc = 0; cyc < cycles; cyc++) begin
         chk("rnd_rvalid", rvalid, exp_rv);
         for (int p = 0; p < NP; p++)
            if (exp_rv[p] && exp_rd) chk("rnd_rdata", rdata[p*DW +: DW], exp_data);
         for (int p = 0; p < NP; p++) begin
            if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
               pend[p]   = 1'b1;
               p_we[p]   = 1'($urandom_range(0, 1));
               p_addr[p] = AW'(32'h100 + $urandom_range(0, 15));
               p_be[p]   = BW'($urandom);
               p_data[p] = $urandom;
            end
            req[p] = pend[p];
            we[p]  = pend[p] && p_we[p];
            addr[p*AW +: AW]  = p_addr[p];
            be[p*BW +: BW]    = p_be[p];
            wdata[p*DW +: DW] = p_data[p];
         end
         #1;
         w = -1;
`ifdef SP_RAM_ARB_RR_EN
         for (int k = 1; k <= NP; k++) begin
            c = (m_last + k) % NP;
            if (w < 0 && pend[c]) w = c;
         end
`else
         for (int k = 0; k < NP; k++) if (w < 0 && pend[k]) w = k;
`endif
         exp_gnt = '0;
         if (w >= 0) exp_gnt[w] = 1'b1;
         chk("rnd_gnt", gnt, exp_gnt);
         chk("rnd_ram_en", ram_en, w >= 0);
         c = 0;
         for (int p = 0; p < NP; p++) if (pend[p]) c++;
         if (c > 1 && m_cnt < 16'hFFFF) m_cnt++;
         exp_rv = exp_gnt;
         if (w >= 0) begin
            chk("rnd_ram_addr", ram_addr, p_addr[w]);
            chk("rnd_ram_we", ram_we, p_we[w]);
            m_last = w;
            exp_rd = !p_we[w];
            if (p_we[w]) begin
               chk("rnd_ram_wdata", ram_wdata, p_data[w]);
               chk("rnd_ram_be", ram_be, p_be[w]);
               for (int b = 0; b < BW; b++)
                  if (p_be[w][b]) ref_mem[p_addr[w][3:0]][8*b +: 8] = p_data[w][8*b +: 8];
            end else begin
               exp_data = ref_mem[p_addr[w][3:0]];
            end
            pend[w] = 1'b0;
         end
         tick();
      end
      chk("rnd_conflict_cnt", cnt, 16'(m_cnt));
      idle_all();
   endtask

   initial begin
      logic [NP-1:0] prev, eg;
      logic [DW-1:0] got;
      int            n0, n1;

      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

      // Reset and idle.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("idle_gnt", gnt, '0);
         chk("idle_ram_en", ram_en, 1'b0);
         chk("idle_rvalid", rvalid, '0);
         tick();
      end
      chk("idle_conflict_cnt", cnt, 16'h0);

      // Grant table, starting from reset state.
      tbl[0] = '{2'b00, 2'b00, 2'b00};
      tbl[1] = '{2'b10, 2'b10, 2'b10};
      tbl[2] = '{2'b11, 2'b01, 2'b01};
      tbl[3] = '{2'b11, 2'b10, 2'b01};
      tbl[4] = '{2'b01, 2'b01, 2'b01};
      tbl[5] = '{2'b00, 2'b00, 2'b00};
      tbl[6] = '{2'b11, 2'b10, 2'b01};
      tbl[7] = '{2'b10, 2'b10, 2'b10};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         req = tbl[i].req;
         #1;
`ifdef SP_RAM_ARB_RR_EN
         prev = tbl[i].gnt_rr;
`else
         prev = tbl[i].gnt_fp;
`endif
         chk("tbl_gnt", gnt, prev);
         chk("tbl_ram_en", ram_en, |prev);
         tick();
         chk("tbl_rvalid", rvalid, prev);
      end
      idle_all();
      tick();

      // Port 1 write then read back.
      access(1, 1'b1, 15'h0040, 4'hF, 32'hDEADBEEF, got);
      access(1, 1'b0, 15'h0040, 4'h0, 32'h0, got);
      chk("wr_rd_data", got, 32'hDEADBEEF);

      // Byte-lane write merge.
      access(0, 1'b1, 15'h0080, 4'hF, 32'h11223344, got);
      access(0, 1'b1, 15'h0080, 4'b0010, 32'h0000AB00, got);
      access(0, 1'b0, 15'h0080, 4'h0, 32'h0, got);
      chk("byte_merge", got, 32'h1122AB44);

      // Both ports requesting for 8 cycles.
      do_reset();
      n0 = 0; n1 = 0;
      req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         #1;
`ifdef SP_RAM_ARB_RR_EN
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
         eg = 2'b01;
`endif
         chk("conf_gnt", gnt, eg);
         if (gnt[0]) n0++;
         if (gnt[1]) n1++;
         tick();
      end
      idle_all();
      chk("conf_cnt8", cnt, 16'd8);
`ifdef SP_RAM_ARB_RR_EN
      chk("conf_n0", 32'(n0), 32'd4);
      chk("conf_n1", 32'(n1), 32'd4);
`else
      chk("conf_n0", 32'(n0), 32'd8);
      chk("conf_n1", 32'(n1), 32'd0);
`endif

      // Reset the cycle after a grant.
      do_reset();
      req = 2'b01;
      #1;
      chk("rst_mid_gnt", gnt, 2'b01);
      tick();
      idle_all();
      chk("rst_mid_rvalid_pre", rvalid, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rvalid_async", rvalid, 2'b00);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mid_rvalid_after", rvalid, 2'b00);
      end

      // Counter saturation.
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 65534; i++) tick();
      chk("sat_fffe", cnt, 16'hFFFE);
      tick();
      chk("sat_ffff", cnt, 16'hFFFF);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_hold", cnt, 16'hFFFF);
      idle_all();

      run_random(2000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
